frame_loader: RTL and testbench

//   Streaming pixel ingest stage feeding conv2d. Accepts one pixel per beat over a

---
 rtl/frame_loader_pkg.sv | 19 +
 rtl/frame_loader.sv | 89 ++++++++
 tb/tb_frame_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/frame_loader_pkg.sv
// rtl/frame_loader_pkg.sv - shared frame geometry defaults and FSM encoding for frame_loader
package frame_loader_pkg;

    localparam int ROWS      = 27;
    localparam int COLS      = 27;
    localparam int CHANNELS  = 1;
    localparam int DATA_SIZE = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Counter width, kept at least one bit so a 1-pixel frame still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - packs a valid/ready pixel stream into a held flat frame vector
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int rows      = ROWS,
    parameter int cols      = COLS,
    parameter int channels  = CHANNELS,
    parameter int data_size = DATA_SIZE
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic [data_size-1:0]                      s_data,
    input  logic                                      s_last,
    output logic [rows*cols*channels*data_size-1:0]   frame_out,
    output logic                                      frame_valid,
    input  logic                                      frame_ack,
    output logic                                      err_short,
    output logic                                      err_long
);

    localparam int NPIX = rows * cols * channels;
    localparam int CW   = cnt_width(NPIX);
    localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

    state_e                          state_q, state_d;
    logic [CW-1:0]                   count_q, count_d;
    logic [NPIX*data_size-1:0]       frame_q, frame_d;
    logic                            err_short_q, err_short_d;
    logic                            err_long_q, err_long_d;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        frame_d     = frame_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;

        unique case (state_q)
            FILL: begin
                if (s_valid) begin
                    frame_d[int'(count_q)*data_size +: data_size] = s_data;
                    if (count_q == LAST_IDX) begin
                        state_d    = HOLD;
                        count_d    = '0;
                        err_long_d = ~s_last;
                    end else if (s_last) begin
                        // Early s_last: drop the partial frame and restart at pixel 0.
                        err_short_d = 1'b1;
                        count_d     = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d = FILL;
                    count_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            count_q     <= '0;
            frame_q     <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            frame_q     <= frame_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign s_ready     = (state_q == FILL);
    assign frame_valid = (state_q == HOLD);
    assign frame_out   = frame_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;

endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - directed self-checking bench for frame_loader on a 3x3x1 frame
module tb_frame_loader;

    localparam int ROWS_T = 3;
    localparam int COLS_T = 3;
    localparam int CH_T   = 1;
    localparam int DW_T   = 8;
    localparam int FW     = ROWS_T * COLS_T * CH_T * DW_T;

    logic            clk;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [DW_T-1:0] s_data;
    logic            s_last;
    logic [FW-1:0]   frame_out;
    logic            frame_valid;
    logic            frame_ack;
    logic            err_short;
    logic            err_long;

    int vectors;
    int miscompares;

    frame_loader #(
        .rows      (ROWS_T),
        .cols      (COLS_T),
        .channels  (CH_T),
        .data_size (DW_T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .err_short   (err_short),
        .err_long    (err_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW_T-1:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_data  = 8'hEE;
        s_last  = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check("ack_fv_low", FW'(frame_valid), FW'(1'b0));
        check("ack_ready_high", FW'(s_ready), FW'(1'b1));
    endtask

    logic [FW-1:0] held;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        frame_ack   = 1'b0;

        #12;
        check("rst_frame_out", frame_out, '0);
        check("rst_fv", FW'(frame_valid), '0);
        check("rst_ready", FW'(s_ready), FW'(1'b1));
        check("rst_errs", FW'({err_short, err_long}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Nominal frame 0x01..0x09
        for (int i = 1; i <= 9; i++) begin
            if (i == 9) check("nom_fv_before_last", FW'(frame_valid), '0);
            send(8'(i), i == 9);
        end
        check("nom_fv", FW'(frame_valid), FW'(1'b1));
        check("nom_frame", frame_out, 72'h090807060504030201);
        check("nom_errs", FW'({err_short, err_long}), '0);

        // Backpressure: hold for 20 cycles, offered beats must be refused
        held    = 72'h090807060504030201;
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_ready_low", FW'(s_ready), '0);
            check("bp_frame_stable", frame_out, held);
            tick();
        end
        s_valid = 1'b0;
        check("bp_fv_still", FW'(frame_valid), FW'(1'b1));
        ack();

        // Short frame: s_last on beat 4, ack asserted meanwhile must be ignored
        frame_ack = 1'b1;
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), i == 3);
        frame_ack = 1'b0;
        check("short_err", FW'(err_short), FW'(1'b1));
        check("short_no_long", FW'(err_long), '0);
        check("short_no_fv", FW'(frame_valid), '0);
        check("short_ready", FW'(s_ready), FW'(1'b1));
        tick();
        check("short_pulse_1cyc", FW'(err_short), '0);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("refill_fv_before_last", FW'(frame_valid), '0);
            send(8'hA0 + 8'(i), i == 8);
        end
        check("refill_fv", FW'(frame_valid), FW'(1'b1));
        check("refill_frame", frame_out, 72'hA8A7A6A5A4A3A2A1A0);
        check("refill_errs", FW'({err_short, err_long}), '0);
        ack();

        // Long frame: no s_last on the 9th beat
        for (int i = 0; i < 9; i++) send(8'h11 + 8'(i), 1'b0);
        check("long_err", FW'(err_long), FW'(1'b1));
        check("long_no_short", FW'(err_short), '0);
        check("long_fv", FW'(frame_valid), FW'(1'b1));
        check("long_frame", frame_out, 72'h191817161514131211);
        tick();
        check("long_pulse_1cyc", FW'(err_long), '0);
        ack();

        // Bubbles: idle cycles carry s_last=1 and junk data that must be ignored
        for (int i = 0; i < 9; i++) begin
            while ($urandom_range(1, 0) == 1) begin
                s_valid = 1'b0;
                s_data  = 8'hFF;
                s_last  = 1'b1;
                tick();
                check("bub_no_err", FW'({err_short, err_long}), '0);
                check("bub_no_fv", FW'(frame_valid), '0);
            end
            send(8'h80 + 8'(i), i == 8);
        end
        check("bub_fv", FW'(frame_valid), FW'(1'b1));
        check("bub_frame", frame_out, 72'h888786858483828180);
        ack();

        // Reset mid-frame, asserted away from any clock edge
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("amid_rst_frame", frame_out, '0);
        check("amid_rst_fv", FW'(frame_valid), '0);
        check("amid_rst_ready", FW'(s_ready), FW'(1'b1));
        check("amid_rst_errs", FW'({err_short, err_long}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("post_rst_fv_before_last", FW'(frame_valid), '0);
            send(8'h31 + 8'(i), i == 8);
        end
        check("post_rst_fv", FW'(frame_valid), FW'(1'b1));
        check("post_rst_frame", frame_out, 72'h393837363534333231);
        check("post_rst_errs", FW'({err_short, err_long}), '0);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
